// File: rtl/trap_sequencer_if.sv
// Trap sequencer signal bundle: pipeline event inputs, flush/redirect strobes and trap CSR state.
// The slave modport is the sequencer; the master modport is the pipeline core side.
interface trap_sequencer_if;
  logic        irq_i;
  logic        illegal_id_i;
  logic [63:0] id_pc_i;
  logic        mem_fault_i;
  logic [63:0] mem_pc_i;
  logic        mret_i;
  logic [63:0] mtvec_i;
  logic        flush_ifid_o;
  logic        flush_idex_o;
  logic        flush_exmem_o;
  logic        flush_memwb_o;
  logic        pc_redirect_o;
  logic [63:0] pc_target_o;
  logic [63:0] mepc_o;
  logic [4:0]  mcause_o;
  logic        mie_o;
  logic        busy_o;
  logic [15:0] trap_count_o;

  modport slave (
    input  irq_i, illegal_id_i, id_pc_i, mem_fault_i, mem_pc_i, mret_i, mtvec_i,
    output flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o,
    output pc_redirect_o, pc_target_o, mepc_o, mcause_o, mie_o, busy_o, trap_count_o
  );

  modport master (
    output irq_i, illegal_id_i, id_pc_i, mem_fault_i, mem_pc_i, mret_i, mtvec_i,
    input  flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o,
    input  pc_redirect_o, pc_target_o, mepc_o, mcause_o, mie_o, busy_o, trap_count_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: captures faults, flushes the pipeline and redirects fetch.
// Define TRAP_IRQ_EN to enable the external interrupt path and a functional mie_o.
//
// state    | meaning
// IDLE     | normal execution, watching for trap events
// FLUSH    | flush strobes active for the captured cause
// REDIRECT | fetch redirected to mtvec, mie cleared, trap counted
// IN_TRAP  | handler running; mret returns, any fault halts
// RETURN   | fetch redirected to mepc, mie set
// HALT     | double fault; only reset leaves
module trap_sequencer (
  input  logic            clk,
  input  logic            rst_n,
  trap_sequencer_if.slave bus
);
`ifdef TRAP_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, FLUSH, REDIRECT, IN_TRAP, RETURN, HALT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  flush_q, flush_d;
  logic        redirect_q, redirect_d;
  logic [63:0] target_q, target_d;
  logic [63:0] mepc_q, mepc_d;
  logic [4:0]  mcause_q, mcause_d;
  logic [15:0] count_q, count_d;
  logic        mie_q, mie_d;
  logic        irq_take;

  assign irq_take = IRQ_EN & bus.irq_i & mie_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      flush_q    <= '0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      count_q    <= '0;
      mie_q      <= IRQ_EN;
    end else begin
      state_q    <= state_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      count_q    <= count_d;
      mie_q      <= mie_d;
    end
  end

  // Strobe registers are loaded with the values for the state being entered.
  always_comb begin
    state_d    = state_q;
    flush_d    = '0;
    redirect_d = 1'b0;
    target_d   = '0;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    count_d    = count_q;
    mie_d      = mie_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_fault_i) begin
          state_d  = FLUSH;
          flush_d  = 4'b1111;
          mepc_d   = bus.mem_pc_i;
          mcause_d = 5'h05;
        end else if (bus.illegal_id_i || bus.mret_i) begin
          state_d  = FLUSH;
          flush_d  = 4'b0011;
          mepc_d   = bus.id_pc_i;
          mcause_d = 5'h02;
        end else if (irq_take) begin
          state_d  = FLUSH;
          flush_d  = 4'b0011;
          mepc_d   = bus.id_pc_i;
          mcause_d = 5'h1B;
        end
      end
      FLUSH: begin
        state_d    = REDIRECT;
        redirect_d = 1'b1;
        target_d   = bus.mtvec_i;
        mie_d      = 1'b0;
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
      end
      REDIRECT: state_d = IN_TRAP;
      IN_TRAP: begin
        if (bus.mem_fault_i || bus.illegal_id_i) begin
          state_d = HALT;
        end else if (bus.mret_i) begin
          state_d    = RETURN;
          redirect_d = 1'b1;
          target_d   = mepc_q;
          flush_d    = 4'b0001;
          mie_d      = IRQ_EN;
        end
      end
      RETURN:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign bus.flush_ifid_o  = flush_q[0];
  assign bus.flush_idex_o  = flush_q[1];
  assign bus.flush_exmem_o = flush_q[2];
  assign bus.flush_memwb_o = flush_q[3];
  assign bus.pc_redirect_o = redirect_q;
  assign bus.pc_target_o   = target_q;
  assign bus.mepc_o        = mepc_q;
  assign bus.mcause_o      = mcause_q;
  assign bus.mie_o         = mie_q;
  assign bus.trap_count_o  = count_q;
  assign bus.busy_o        = (state_q == FLUSH) || (state_q == REDIRECT) ||
                             (state_q == RETURN) || (state_q == HALT);
endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 clk  input  1  core clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 irq_i  input  1  external interrupt request, level-sensitive.
REQ-004 illegal_id_i  input  1  illegal opcode decoded in ID this cycle.
REQ-005 id_pc_i  input  64  PC of instruction in ID.
REQ-006 mem_fault_i  input  1  load/store access fault in MEM this cycle.
REQ-007 mem_pc_i  input  64  PC of instruction in MEM.
REQ-008 mret_i  input  1  exception-return decoded in ID this cycle.
REQ-009 mtvec_i  input  64  trap handler base address.
REQ-010 flush_ifid_o, flush_idex_o, flush_exmem_o, flush_memwb_o  output  1 each  pipeline-register flush strobes.
REQ-011 pc_redirect_o  output  1  load pc_target_o into PC this cycle.
REQ-012 pc_target_o  output  64  redirect address.
REQ-013 mepc_o  output  64  saved trap PC.
REQ-014 mcause_o  output  5  bit4 = interrupt, bits3:0 = code.
REQ-015 mie_o  output  1  interrupt enable.
REQ-016 busy_o  output  1  high in FLUSH, REDIRECT, RETURN, HALT; front end stalls fetch.
REQ-017 trap_count_o  output  16  number of traps taken, saturating.

Function
REQ-018 States SHALL be IDLE, FLUSH, REDIRECT, IN_TRAP, RETURN, HALT.
REQ-019 IDLE: event sampled at edge N -> FLUSH at N+1 -> REDIRECT at N+2 -> IN_TRAP at N+3.
REQ-020 Event priority in IDLE SHALL be mem_fault_i > illegal_id_i > mret_i (illegal outside trap) > (irq_i & mie_o).
REQ-021 On capture: mem_fault -> mepc=mem_pc_i, mcause=5'h05; illegal or mret-in-IDLE -> mepc=id_pc_i, mcause=5'h02; irq -> mepc=id_pc_i, mcause=5'h1B.
REQ-022 FLUSH (one cycle): mem_fault asserts all four flushes; other causes assert flush_ifid_o and flush_idex_o only.
REQ-023 REDIRECT (one cycle): pc_redirect_o=1, pc_target_o=mtvec_i; mie_o cleared; trap_count_o increments unless at 16'hFFFF.
REQ-024 IN_TRAP: irq_i ignored; mret_i -> RETURN; mem_fault_i or illegal_id_i -> HALT (double fault).
REQ-025 Simultaneous mret_i and fault in IN_TRAP: fault wins, -> HALT.
REQ-026 RETURN (one cycle): pc_redirect_o=1, pc_target_o=mepc_o, flush_ifid_o=1, mie_o set; -> IDLE.
REQ-027 HALT: busy_o=1, all strobes 0, all inputs ignored; exits only via rst_n.
REQ-028 Flush and redirect strobes SHALL be registered, single-cycle pulses; 0 in every other state.
REQ-029 mepc_o and mcause_o SHALL hold until the next capture; HALT does not overwrite them.
REQ-030 pc_target_o SHALL be 0 when pc_redirect_o=0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, all strobes 0, busy_o=0, mepc_o=0, mcause_o=0, trap_count_o=0, mie_o=1.
REQ-032 Reset asserted mid-sequence (any state) SHALL abandon it; no redirect issued after release.
REQ-033 The first capture SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-034 Macro TRAP_IRQ_EN defined: irq_i path per REQ-020/021, mie_o functional.
REQ-035 TRAP_IRQ_EN undefined: irq_i ignored, mie_o tied 0, mcause bit4 always 0; all other behaviour unchanged.

Verification
REQ-036 IDLE, mem_fault_i=1, mem_pc_i=0x1000 -> N+1 four flushes; N+2 redirect to mtvec_i=0x8000; mepc_o=0x1000, mcause_o=0x05, trap_count_o=1.
REQ-037 IDLE, illegal_id_i=1 and irq_i=1 same cycle, id_pc_i=0x2004 -> mcause_o=0x02, only IF/ID and ID/EX flushed, mepc_o=0x2004.
REQ-038 IN_TRAP, mret_i=1 -> next cycle redirect to mepc_o with flush_ifid_o=1, mie_o=1, state IDLE.
REQ-039 IN_TRAP, mret_i=1 and mem_fault_i=1 -> HALT, busy_o=1, no redirect, mepc_o unchanged.
REQ-040 rst_n pulsed low in REDIRECT -> pc_redirect_o=0 immediately, trap_count_o=0, no redirect after release.
REQ-041 TRAP_IRQ_EN undefined, irq_i=1 for 10 cycles in IDLE -> no flush, redirect, or count change.
